// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data widths and the
// fetch controller state encoding.
package inst_fetch_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {pc, inst} words whose head entry
// is held in a dedicated output register.
module fetch_fifo import inst_fetch_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2 * XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_next = rd_ptr + 1'b1;
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // head mirrors mem[rd_ptr] but only changes when a new entry reaches the
  // front, so it keeps the last word once the buffer drains or is flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (do_pop && (count > ONE_CNT)) begin
        head <= mem[rd_next];
      end else if (do_push && (empty || do_pop)) begin
        head <= push_data;
      end
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding request controller feeding a
// small instruction buffer, with redirect flush and stale-response draining.
module inst_fetch import inst_fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] Inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_state_t      state, state_n;
  logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
  logic              mem_req_n;
  logic              push, pop, full, empty;
  logic [AW:0]       count, count_n;
  logic [2*XLEN-1:0] head;

  assign mem_addr   = fetch_pc;
  assign inst_valid = !empty;
  assign Inst       = head[XLEN-1:0];
  assign inst_pc    = head[2*XLEN-1:XLEN];
  assign pop        = inst_valid && inst_ready && !redirect;
  assign count_n    = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    unique case (state)
      ST_IDLE: state_n = ST_REQ;
      ST_REQ: begin
        if (mem_req && mem_gnt) begin
          state_n    = redirect ? ST_DRAIN : ST_WAIT;
          fetch_pc_n = fetch_pc + XLEN'(WORD_BYTES);
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_n = ST_REQ;
          push    = !redirect && (!full || pop);
        end else if (redirect) begin
          state_n = ST_DRAIN;
        end
      end
      // a redirect here only retargets; a response in the same cycle still
      // retires the outstanding request
      ST_DRAIN: if (mem_rvalid) state_n = ST_REQ;
      default:  state_n = ST_IDLE;
    endcase
    if (redirect) fetch_pc_n = {redirect_pc[XLEN-1:2], 2'b00};
    mem_req_n = (state_n == ST_REQ) && !redirect && (count_n < FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_req  <= mem_req_n;
    end
  end

  // in WAIT fetch_pc has already advanced, so the issued address is one word back
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({fetch_pc - XLEN'(WORD_BYTES), mem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed phases plus randomized traffic
// against a program-order reference model of fetch addresses and consumed words.
module tb_inst_fetch;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        mem_req, mem_gnt, mem_rvalid, inst_valid, inst_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, Inst, inst_pc, redirect_pc;
  logic        w_req, w_gnt, w_rvalid, w_valid, w_ready, w_redirect;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_redirect_pc;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .Inst(Inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .redirect(redirect), .redirect_pc(redirect_pc));

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .reset(reset), .mem_req(w_req), .mem_addr(w_addr),
    .mem_gnt(w_gnt), .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
    .Inst(w_inst), .inst_valid(w_valid), .inst_ready(w_ready),
    .inst_pc(w_pc), .redirect(w_redirect), .redirect_pc(w_redirect_pc));

  int errors = 0;
  int checks = 0;

  // reference model state
  int          occ, pend_cnt, dut_pops;
  logic [31:0] exp_fetch, exp_pc, pend_addr;
  bit          pend, pend_live;
  bit          prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;
  bit          cap_pop, cap_hs;
  logic [31:0] cap_pop_pc, cap_hs_addr;
  bit          w_pend;
  logic [31:0] w_pend_addr, w_exp_fetch, w_exp_pc;
  logic [31:0] w_addrs[$];

  // stimulus knobs
  int unsigned gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
  bit          redir_now = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit rv, rd, hs, pop, push;
    logic [31:0] tgt;
    @(negedge clk);
    chk("valid_vs_model", 32'(inst_valid), 32'(occ != 0));
    if (pend) chk("one_outstanding", 32'(mem_req), 32'd0);
    if (occ >= int'(DEPTH)) chk("req_when_full", 32'(mem_req), 32'd0);
    if (prev_req && !prev_gnt && !prev_redir) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, prev_addr);
    end
    rv = pend && (pend_cnt == 0);
    if (pend && pend_cnt > 0) pend_cnt--;
    rd = redir_now;
    tgt = redir_target;
    redir_now = 1'b0;
    mem_gnt     = ($urandom_range(99) < gnt_pct);
    inst_ready  = ($urandom_range(99) < ready_pct);
    mem_rvalid  = rv;
    mem_rdata   = rv ? rom(pend_addr) : $urandom;
    redirect    = rd;
    redirect_pc = rd ? tgt : ($urandom & 32'hFFFF_FFFC);

    hs = mem_req && mem_gnt;
    if (hs) begin
      chk("fetch_addr", mem_addr, exp_fetch);
      if (cap_hs && !rd) begin cap_hs_addr = mem_addr; cap_hs = 1'b0; end
    end
    if (inst_valid && inst_ready && !rd) dut_pops++;
    pop = (occ != 0) && inst_ready && !rd;
    if (pop) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_word", Inst, rom(exp_pc));
      if (cap_pop) begin cap_pop_pc = inst_pc; cap_pop = 1'b0; end
      exp_pc = exp_pc + 32'd4;
    end
    push = rv && pend_live && !rd;
    if (rv) pend = 1'b0;
    if (rd) begin
      occ = 0; exp_fetch = tgt; exp_pc = tgt; pend_live = 1'b0;
    end else begin
      occ = occ + int'(push) - int'(pop);
    end
    if (hs) begin
      if (!rd) exp_fetch = exp_fetch + 32'd4;
      pend = 1'b1;
      pend_live = !rd;
      pend_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
      pend_addr = mem_addr;
    end
    prev_req = mem_req; prev_gnt = mem_gnt; prev_redir = rd; prev_addr = mem_addr;

    // wrap instance: always granted, one-cycle responses, always ready
    if (w_valid) begin
      chk("wrap_pc", w_pc, w_exp_pc);
      chk("wrap_inst", w_inst, rom(w_exp_pc));
      w_exp_pc = w_exp_pc + 32'd4;
    end
    if (w_req) begin
      chk("wrap_addr", w_addr, w_exp_fetch);
      w_addrs.push_back(w_addr);
      w_exp_fetch = w_exp_fetch + 32'd4;
    end
    w_rvalid = w_pend;
    w_rdata  = rom(w_pend_addr);
    w_pend = w_req;
    w_pend_addr = w_addr;
  endtask

  task automatic do_reset(input int n, input bit rv_idle);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0000_0000);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", Inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    w_rvalid = 1'b0;
    repeat (n) @(negedge clk);
    occ = 0; exp_fetch = '0; exp_pc = '0; pend = 1'b0; pend_live = 1'b0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
    w_pend = 1'b0; w_exp_fetch = 32'hFFFF_FFF8; w_exp_pc = 32'hFFFF_FFF8;
    w_addrs.delete();
    mem_rvalid = rv_idle;
    mem_rdata  = 32'hDEAD_BEEF;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [31:0] t;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    w_gnt = 1'b1; w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;
    w_rvalid = 1'b0; w_rdata = '0; w_pend_addr = '0; pend_addr = '0;

    // zero-wait streaming after reset, throughput and wrap instance addresses
    do_reset(3, 1'b0);
    repeat (10) cycle();
    dut_pops = 0;
    repeat (20) cycle();
    chk("throughput_pops", 32'(dut_pops), 32'd10);
    chk("wrap_hs_count", 32'(w_addrs.size() >= 3), 32'd1);
    chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", w_addrs[2], 32'h0000_0000);

    // stalled consumer fills the buffer, then drains without new fetches
    ready_pct = 0;
    repeat (10) cycle();
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    ready_pct = 100; gnt_pct = 0; dut_pops = 0;
    repeat (3) cycle();
    chk("drain_pops", 32'(dut_pops), 32'(DEPTH));
    chk("drain_empty", 32'(inst_valid), 32'd0);

    // redirect while a response is outstanding
    gnt_pct = 100; lat_min = 3; lat_max = 3; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin cycle(); ok = pend && (pend_cnt > 0); end
    chk("reach_wait", 32'(ok), 32'd1);
    redir_now = 1'b1; redir_target = 32'h0000_0100; cap_pop = 1'b1; cap_hs = 1'b1;
    cycle();
    for (int i = 0; i < 30 && cap_pop; i++) cycle();
    chk("redir_captured", 32'(cap_pop || cap_hs), 32'd0);
    chk("redir_first_addr", cap_hs_addr, 32'h0000_0100);
    chk("redir_first_pc", cap_pop_pc, 32'h0000_0100);

    // redirect coinciding with a pop on a full buffer
    lat_min = 1; lat_max = 1; ready_pct = 0;
    repeat (12) cycle();
    chk("pre_flush_full", 32'(occ), 32'(DEPTH));
    ready_pct = 100; redir_now = 1'b1; redir_target = 32'h0000_0200;
    cycle();
    @(posedge clk);
    #1 chk("flush_valid", 32'(inst_valid), 32'd0);

    // randomized traffic with occasional redirects, some near the wrap point
    gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(29) == 0) begin
        t = $urandom;
        t[1:0] = 2'b00;
        redir_now = 1'b1;
        redir_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : t;
      end
      cycle();
    end

    // reset during an outstanding request; stale response lands in IDLE
    gnt_pct = 100; ready_pct = 100; lat_min = 6; lat_max = 6; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin cycle(); ok = pend && (pend_cnt > 0); end
    chk("reach_wait_rst", 32'(ok), 32'd1);
    do_reset(2, 1'b1);
    lat_min = 1; lat_max = 1;
    cycle();
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0000_0000);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-007 mem_gnt  input  1  memory accepts request this cycle (mem_req & mem_gnt = handshake).
REQ-008 mem_rvalid  input  1  read data valid.
REQ-009 mem_rdata  input  32  fetched instruction word.
REQ-010 Inst  output  32  instruction presented to processor.
REQ-011 inst_valid  output  1  Inst and inst_pc valid.
REQ-012 inst_ready  input  1  processor consumes Inst (inst_valid & inst_ready = pop).
REQ-013 inst_pc  output  32  address of Inst.
REQ-014 redirect  input  1  branch/jump redirect strobe.
REQ-015 redirect_pc  input  32  target address, sampled when redirect=1.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DRAIN; exactly one request outstanding at a time.
REQ-017 IDLE: first cycle after reset release; unconditionally -> REQ next cycle.
REQ-018 REQ: mem_req=1 when buffer occupancy + 0 outstanding < DEPTH, else mem_req=0 and remain in REQ; on mem_gnt -> WAIT and fetch_pc += 4.
REQ-019 WAIT: on mem_rvalid, write {fetch-issued pc, mem_rdata} into buffer, -> REQ; response latency unbounded.
REQ-020 DRAIN: entered on redirect during WAIT (or during REQ with mem_gnt same cycle); next mem_rvalid discarded, -> REQ.
REQ-021 mem_addr and mem_req are registered outputs; mem_addr holds stable while mem_req=1 and mem_gnt=0.
REQ-022 fetch_pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-023 Buffer is FIFO; Inst/inst_pc/inst_valid driven from head register; word written by rvalid visible on inst_valid the following cycle.
REQ-024 Full: no mem_req issued; Empty: inst_valid=0, Inst holds last value.
REQ-025 Simultaneous push and pop on full buffer is legal; occupancy unchanged.
REQ-026 Redirect: priority over push/pop in same cycle; buffer flushed (inst_valid=0 next cycle), fetch_pc <= redirect_pc, any rvalid that cycle dropped.
REQ-027 Redirect in REQ without grant: mem_req drops for one cycle, then re-issues at redirect_pc.
REQ-028 Redirect during DRAIN: updates fetch_pc, stays in DRAIN.
REQ-029 mem_rvalid in IDLE or REQ is ignored (stale response after reset).
REQ-030 Sustained throughput: one instruction per two cycles with 0-wait memory.

Reset
REQ-031 reset=0 asynchronously forces: state IDLE, fetch_pc=RESET_PC, buffer empty, mem_req=0, mem_addr=RESET_PC, inst_valid=0, Inst=0, inst_pc=0.
REQ-032 Reset mid-transaction abandons outstanding request; no response is enqueued.

Structure
REQ-033 Package inst_fetch_pkg holds state enum, WORD_BYTES=4, XLEN=32.
REQ-034 Sub-module fetch_fifo (DEPTH x 64-bit {pc,inst}, push/pop/flush, full/empty/count) instantiated once.

Verification
REQ-035 Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> mem_addr 0,4,8; Inst sequence matches ROM, inst_pc 0,4,8.
REQ-036 ready=0 for 10 cycles -> exactly DEPTH=2 words buffered, mem_req=0 while full; ready=1 drains in order, no loss.
REQ-037 redirect to 32'h100 while WAIT -> next rvalid dropped, next mem_addr=32'h100, first Inst after redirect has inst_pc=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 reset asserted during WAIT, rvalid arrives in IDLE -> ignored, inst_valid stays 0, first fetch at RESET_PC.
REQ-040 redirect coincident with push and pop on full buffer -> buffer empty next cycle, no stale Inst presented.
